// File: rtl/uc_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uc_pkg : shared types and constants for the fetch-stage hazard controller.
//   uc_hz_state_t : FSM state encoding (3 bits)
//   STALL_CNT_W   : width of the optional stall statistic counter
// -----------------------------------------------------------------------------
package uc_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        JMP_WAIT = 3'd1,
        MEM_WAIT = 3'd2,
        FLUSH    = 3'd3,
        IRQ      = 3'd4
    } uc_hz_state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/uc_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// uc_hazard_ctrl_if : hazard request / fetch control bundle.
//   master : decoder + memory + interrupt side (drives requests, sees controls)
//   slave  : uc_hazard_ctrl (sees requests, drives fetch controls)
// Signals: cjmp_req, cjmp_taken, mem_req, mem_ack, irq_req (requests);
//          irq_ack, fetch_hold, flush, pc_load, mem_timeout, busy,
//          stall_cycles (controls / status).
// -----------------------------------------------------------------------------
interface uc_hazard_ctrl_if;
    import uc_pkg::*;

    logic                   cjmp_req;
    logic                   cjmp_taken;
    logic                   mem_req;
    logic                   mem_ack;
    logic                   irq_req;
    logic                   irq_ack;
    logic                   fetch_hold;
    logic                   flush;
    logic                   pc_load;
    logic                   mem_timeout;
    logic                   busy;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output cjmp_req, cjmp_taken, mem_req, mem_ack, irq_req,
        input  irq_ack, fetch_hold, flush, pc_load, mem_timeout, busy, stall_cycles
    );

    modport slave (
        input  cjmp_req, cjmp_taken, mem_req, mem_ack, irq_req,
        output irq_ack, fetch_hold, flush, pc_load, mem_timeout, busy, stall_cycles
    );

endinterface

// File: rtl/uc_penalty_cnt.sv
// -----------------------------------------------------------------------------
// uc_penalty_cnt : loadable up/down counter shared by JMP_WAIT and MEM_WAIT.
//   clk, reset (async, active-high)
//   i_load / i_load_val : load has priority over inc, inc over dec
//   i_inc, i_dec        : count up / down by one
//   o_cnt               : current count
//   o_is_one            : count equals 1 (last jump-penalty cycle)
// -----------------------------------------------------------------------------
module uc_penalty_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_is_one
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/uc_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// uc_hazard_ctrl : fetch-stage stall/flush scheduler (Moore FSM).
//   clk   : system clock
//   reset : asynchronous, active-high; aborts any sequence back to RUN
//   hz    : uc_hazard_ctrl_if.slave (requests in, fetch controls out)
// Services one hazard at a time; in RUN the priority is
// mem_req > cjmp_req > irq_req. A shared counter times both the jump penalty
// (counts down) and the memory wait (counts up to the timeout).
// Optional macro UC_HAZARD_STATS_EN: adds a saturating 16-bit count of
// fetch_hold cycles on stall_cycles; otherwise stall_cycles is tied to 0.
// -----------------------------------------------------------------------------
module uc_hazard_ctrl
    import uc_pkg::*;
#(
    parameter int unsigned JMP_PENALTY  = 2,
    parameter int unsigned MEM_WAIT_MAX = 7,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    uc_hazard_ctrl_if.slave  hz
);

    // A zero penalty still needs one cycle to resolve the condition.
    localparam int unsigned      JMP_LOAD_I = (JMP_PENALTY == 0) ? 1 : JMP_PENALTY;
    localparam int unsigned      MEM_LAST_I = MEM_WAIT_MAX - 1;
    localparam logic [CNT_W-1:0] JMP_LOAD   = JMP_LOAD_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] MEM_LAST   = MEM_LAST_I[CNT_W-1:0];

    uc_hz_state_t     r_state;
    uc_hz_state_t     w_state_next;
    logic             r_mem_timeout;
    logic             w_mem_timeout_next;

    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_inc;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_is_one;
    logic             w_fetch_hold;

    uc_penalty_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_inc      (w_cnt_inc),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_cnt),
        .o_is_one   (w_cnt_is_one)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RUN;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_mem_timeout <= w_mem_timeout_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_mem_timeout_next = 1'b0;
        w_cnt_load         = 1'b0;
        w_cnt_load_val     = '0;
        w_cnt_inc          = 1'b0;
        w_cnt_dec          = 1'b0;
        case (r_state)
            RUN: begin
                if (hz.mem_req) begin
                    w_state_next = MEM_WAIT;
                    w_cnt_load   = 1'b1;
                end else if (hz.cjmp_req) begin
                    w_state_next   = JMP_WAIT;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = JMP_LOAD;
                end else if (hz.irq_req) begin
                    w_state_next = IRQ;
                end
            end
            JMP_WAIT: begin
                w_cnt_dec = 1'b1;
                // cjmp_taken is only meaningful on the final penalty cycle.
                if (w_cnt_is_one) begin
                    w_state_next = hz.cjmp_taken ? FLUSH : RUN;
                end
            end
            MEM_WAIT: begin
                // A late ack wins over the timeout on the same cycle.
                if (hz.mem_ack) begin
                    w_state_next = RUN;
                end else if (w_cnt == MEM_LAST) begin
                    w_state_next       = RUN;
                    w_mem_timeout_next = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            FLUSH:   w_state_next = RUN;
            IRQ:     w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    assign w_fetch_hold   = (r_state != RUN);
    assign hz.fetch_hold  = w_fetch_hold;
    assign hz.busy        = w_fetch_hold;
    assign hz.flush       = (r_state == FLUSH) || (r_state == IRQ);
    assign hz.pc_load     = (r_state == FLUSH) || (r_state == IRQ);
    assign hz.irq_ack     = (r_state == IRQ);
    assign hz.mem_timeout = r_mem_timeout;

`ifdef UC_HAZARD_STATS_EN
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_fetch_hold && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign hz.stall_cycles = r_stall_cycles;
`else
    assign hz.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_uc_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uc_hazard_ctrl : self-checking bench for uc_hazard_ctrl.
// Each hazard transaction is expanded into per-cycle input/expected-output
// entries from the controller's rules (hold lengths, flush, timeout, irq
// ordering); a runner applies the inputs and compares the outputs.
// -----------------------------------------------------------------------------
module tb_uc_hazard_ctrl;

    localparam int unsigned JMP_PENALTY  = 2;
    localparam int unsigned MEM_WAIT_MAX = 7;
    localparam int unsigned CNT_W        = 3;
    localparam int          PEN          = (JMP_PENALTY == 0) ? 1 : JMP_PENALTY;

    // Expected output bits: {irq_ack, fetch_hold, flush, pc_load, mem_timeout, busy}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_HOLD  = 6'b010001;
    localparam logic [5:0] O_FLUSH = 6'b011101;
    localparam logic [5:0] O_IRQ   = 6'b111101;
    localparam logic [5:0] O_TMO   = 6'b000010;

    typedef struct packed {
        logic cjmp_req;
        logic cjmp_taken;
        logic mem_req;
        logic mem_ack;
        logic irq_req;
    } in_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_stall = 0;

    in_t        q_in[$];
    logic [5:0] q_exp[$];
    string      q_tag[$];

    uc_hazard_ctrl_if hz_if();

    uc_hazard_ctrl #(
        .JMP_PENALTY  (JMP_PENALTY),
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {hz_if.irq_ack, hz_if.fetch_hold, hz_if.flush,
                hz_if.pc_load, hz_if.mem_timeout, hz_if.busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input in_t v);
        hz_if.cjmp_req   = v.cjmp_req;
        hz_if.cjmp_taken = v.cjmp_taken;
        hz_if.mem_req    = v.mem_req;
        hz_if.mem_ack    = v.mem_ack;
        hz_if.irq_req    = v.irq_req;
    endtask

    function automatic void push(input in_t v, input logic [5:0] e, input string tag);
        q_in.push_back(v);
        q_exp.push_back(e);
        q_tag.push_back(tag);
        if (e[4]) exp_stall++;
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) push(5'b00000, O_IDLE, "idle");
    endfunction

    // Conditional jump: PEN hold cycles, plus one flush cycle when taken.
    function automatic void add_cjmp(input logic taken);
        push(5'b10000, O_IDLE, "cjmp_issue");
        for (int h = 1; h <= PEN; h++) begin
            in_t v = '0;
            v.cjmp_taken = (h == PEN) ? taken : 1'($urandom);
            v.mem_ack    = 1'($urandom);
            push(v, O_HOLD, "cjmp_hold");
        end
        if (taken) push(5'b00000, O_FLUSH, "cjmp_flush");
    endfunction

    // Memory wait: ack on hold cycle k (1..MAX), k==0 means no ack -> timeout.
    function automatic void add_mem(input int k);
        int hold_n = (k == 0) ? MEM_WAIT_MAX : k;
        push(5'b00100, O_IDLE, "mem_issue");
        for (int h = 1; h <= hold_n; h++) begin
            in_t v = '0;
            v.mem_req = 1'b1;
            v.mem_ack = (h == k);
            push(v, O_HOLD, "mem_hold");
        end
        push(5'b00000, (k == 0) ? O_TMO : O_IDLE, "mem_end");
    endfunction

    function automatic void add_irq();
        push(5'b00001, O_IDLE, "irq_issue");
        push(5'b00000, O_IRQ, "irq_entry");
    endfunction

    // All three at once: memory wins, jump is lost, irq follows after RUN.
    function automatic void add_combo(input int k);
        int hold_n = (k == 0) ? MEM_WAIT_MAX : k;
        push(5'b10101, O_IDLE, "combo_issue");
        for (int h = 1; h <= hold_n; h++) begin
            in_t v = '0;
            v.mem_req = 1'b1;
            v.mem_ack = (h == k);
            v.irq_req = 1'b1;
            push(v, O_HOLD, "combo_mem");
        end
        push(5'b00001, (k == 0) ? O_TMO : O_IDLE, "combo_run");
        push(5'b00000, O_IRQ, "combo_irq");
    endfunction

    function automatic int stall_exp();
`ifdef UC_HAZARD_STATS_EN
        return exp_stall;
`else
        return 0;
`endif
    endfunction

    task automatic run_queue();
        while (q_in.size() > 0) begin
            in_t        v   = q_in.pop_front();
            logic [5:0] e   = q_exp.pop_front();
            string      tag = q_tag.pop_front();
            chk(tag, 32'(outs()), 32'(e));
            apply(v);
            @(posedge clk);
            #1;
        end
        chk("stall_cycles", 32'(hz_if.stall_cycles), 32'(stall_exp()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply(5'b00000);
        #1;
        chk("reset_outs", 32'(outs()), 32'(O_IDLE));
        chk("reset_stall", 32'(hz_if.stall_cycles), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed steps.
        add_idle(10);
        add_cjmp(1'b1);
        add_cjmp(1'b0);
        add_mem(3);
        add_mem(0);
        add_mem(MEM_WAIT_MAX);
        add_mem(1);
        add_combo(2);
        add_irq();
        add_cjmp(1'b1);
        add_irq();
        add_combo(0);
        add_idle(2);
        run_queue();

        // Reset on the last jump-penalty cycle drops the pending flush.
        apply(5'b10000);
        @(posedge clk); #1;
        apply(5'b00000);
        chk("rst_jmp_hold1", 32'(outs()), 32'(O_HOLD));
        @(posedge clk); #1;
        chk("rst_jmp_hold2", 32'(outs()), 32'(O_HOLD));
        #1;
        hz_if.cjmp_taken = 1'b1;
        reset = 1'b1;
        exp_stall = 0;
        #1;
        chk("rst_async_outs", 32'(outs()), 32'(O_IDLE));
        chk("rst_async_stall", 32'(hz_if.stall_cycles), 32'd0);
        @(posedge clk); #1;
        chk("rst_no_flush", 32'(outs()), 32'(O_IDLE));
        #2;
        reset = 1'b0;
        hz_if.cjmp_taken = 1'b0;
        @(posedge clk); #1;
        chk("rst_after", 32'(outs()), 32'(O_IDLE));

        // Randomised mix of transactions.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0:       add_idle(int'($urandom_range(1, 3)));
                1:       add_cjmp(1'($urandom));
                2:       add_mem(int'($urandom_range(0, MEM_WAIT_MAX)));
                3:       add_irq();
                default: add_combo(int'($urandom_range(0, MEM_WAIT_MAX)));
            endcase
        end
        add_idle(2);
        run_queue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uc_hazard_ctrl.md
Name: uc_hazard_ctrl

Overview:
Stall/flush scheduler for the microcontroller fetch stage. Arbitrates three hazard sources (memory wait, conditional-jump resolution, interrupt entry) and sequences fetch_hold, flush and pc_load so that only one hazard is serviced at a time. Sits between the instruction decoder and the PC/fetch logic, replacing ad-hoc per-source hold generation with a single Moore FSM plus a shared cycle counter.

Parameters:
JMP_PENALTY, 2, hold cycles after a conditional jump is decoded; 0 is treated as 1
MEM_WAIT_MAX, 7, maximum MEM_WAIT cycles before timeout abort; range 1..(2^CNT_W - 1)
CNT_W, 3, width of the shared penalty/wait counter; must hold max(JMP_PENALTY, MEM_WAIT_MAX)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high
cjmp_req  in  1  decoder flags a conditional jump this cycle (single-cycle pulse)
cjmp_taken  in  1  jump condition result; valid on the last JMP_WAIT cycle only
mem_req  in  1  memory access needs wait states (level)
mem_ack  in  1  memory access complete
irq_req  in  1  interrupt pending (level; held by source until irq_ack)
irq_ack  out  1  one-cycle acknowledge on interrupt entry
fetch_hold  out  1  freeze PC and instruction register
flush  out  1  invalidate instruction in fetch stage
pc_load  out  1  load PC from jump/vector target mux
mem_timeout  out  1  one-cycle pulse on MEM_WAIT timeout
busy  out  1  FSM not in RUN
stall_cycles  out  16  stall statistic (see Optional Feature)

Behaviour:
- States: RUN, JMP_WAIT, MEM_WAIT, FLUSH, IRQ. Outputs decoded from state only (Moore); no input-to-output combinational path.
- Reset (async): state=RUN, counter=0; all outputs 0, stall_cycles=0.
- RUN: fetch_hold=0, busy=0. Priority on the same cycle: mem_req > cjmp_req > irq_req.
  - mem_req -> MEM_WAIT, counter=0.
  - else cjmp_req -> JMP_WAIT, counter=max(JMP_PENALTY,1).
  - else irq_req -> IRQ.
  - A losing cjmp_req pulse is lost; the decoder must not issue a cjmp while mem_req is high. A losing irq_req is level-held and serviced later.
- JMP_WAIT: fetch_hold=1. Counter decrements each cycle. When counter==1, sample cjmp_taken: 1 -> FLUSH, 0 -> RUN. Total hold is exactly max(JMP_PENALTY,1) cycles, excluding FLUSH.
- MEM_WAIT: fetch_hold=1.
  - mem_ack -> RUN; the ack is honoured even on the timeout cycle.
  - Otherwise the counter increments; when counter==MEM_WAIT_MAX-1 and no ack, go to RUN and pulse mem_timeout in the RUN entry cycle, i.e. a registered pulse.
- FLUSH: one cycle; fetch_hold=1, flush=1, pc_load=1 -> RUN.
- IRQ: one cycle; irq_ack=1, flush=1, pc_load=1, fetch_hold=1 -> RUN. Interrupts are never taken in non-RUN states.
- busy=1 in every state except RUN.
- Counter width is CNT_W; no wrap is reachable given the parameter constraints.
- Reset asserted mid-sequence aborts immediately to RUN; pending flush/pc_load are dropped.

Optional Feature:
- UC_HAZARD_STATS_EN defined: stall_cycles increments on every cycle fetch_hold=1. It is 16-bit, saturates at 0xFFFF and is cleared only by reset.
- Not defined: stall_cycles is tied to 0 and no counter flops are generated.

Decomposition:
- Shared package uc_pkg: state enum uc_hz_state_t (RUN=0, JMP_WAIT=1, MEM_WAIT=2, FLUSH=3, IRQ=4; 3-bit encoding) and localparam STALL_CNT_W=16.
- One natural sub-module: uc_penalty_cnt, a loadable up/down CNT_W counter with load, inc, dec and a zero/one flag, shared by JMP_WAIT and MEM_WAIT.

Test Plan:
- Reset release, no requests -> state RUN, all outputs 0 for 10 cycles.
- cjmp_req pulse, JMP_PENALTY=2, cjmp_taken=1 on 2nd hold cycle -> fetch_hold high 3 cycles; flush=pc_load=1 on 3rd only; then RUN.
- Same with cjmp_taken=0 -> fetch_hold high exactly 2 cycles; flush never asserted.
- mem_req with mem_ack after 3 cycles -> fetch_hold high 3 cycles, no mem_timeout; with no ack, MEM_WAIT_MAX=7 -> 7 hold cycles then a single mem_timeout pulse.
- mem_req, cjmp_req and irq_req simultaneous -> MEM_WAIT first; irq_ack asserted one cycle after return to RUN; cjmp dropped.
- reset asserted during JMP_WAIT counter=1 -> outputs 0 asynchronously, no flush. With UC_HAZARD_STATS_EN, stall_cycles equals the total fetch_hold cycles counted by the bench.
